// File: rtl/pc_unit_btb_pkg.sv
// Shared definitions for the fetch PC unit: 2-bit branch counter encoding
// and a compile-time log2 helper used to carve PC fields for the BTB.
package pc_unit_btb_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // New allocations start weakly taken so one not-taken outcome flips them.
    localparam ctr_e CTR_INIT = CTR_WT;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/pc_unit_btb_if.sv
// Fetch-side bundle: cache/hazard hold controls, EX redirect and BTB update,
// and the registered fetch PC with its branch prediction.
interface pc_unit_btb_if #(
    parameter int WIDTH = 32
);
    logic             hit;
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             upd_en;
    logic [WIDTH-1:0] upd_pc;
    logic [WIDTH-1:0] upd_target;
    logic             upd_taken;
    logic [WIDTH-1:0] outPC;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;

    modport master (
        output hit, stall, redirect, redirect_pc,
        output upd_en, upd_pc, upd_target, upd_taken,
        input  outPC, pred_taken, pred_target
    );

    modport slave (
        input  hit, stall, redirect, redirect_pc,
        input  upd_en, upd_pc, upd_target, upd_taken,
        output outPC, pred_taken, pred_target
    );
endinterface

// File: rtl/pc_unit_btb_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the current PC and sees pre-update contents.
module pc_unit_btb_btb
    import pc_unit_btb_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int BTB_DEPTH   = 16,
    parameter int INSTR_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] lookup_pc_i,
    input  logic             upd_en_i,
    input  logic [WIDTH-1:0] upd_pc_i,
    input  logic [WIDTH-1:0] upd_target_i,
    input  logic             upd_taken_i,
    output logic             pred_taken_o,
    output logic [WIDTH-1:0] pred_target_o
);

    localparam int OFF   = log2_ceil(INSTR_BYTES);
    localparam int IDX   = log2_ceil(BTB_DEPTH);
    localparam int TAG_W = WIDTH - OFF - IDX;

    function automatic ctr_e sat_inc(input ctr_e c);
        case (c)
            CTR_SNT: return CTR_WNT;
            CTR_WNT: return CTR_WT;
            default: return CTR_ST;
        endcase
    endfunction

    function automatic ctr_e sat_dec(input ctr_e c);
        case (c)
            CTR_ST:  return CTR_WT;
            CTR_WT:  return CTR_WNT;
            default: return CTR_SNT;
        endcase
    endfunction

    function automatic logic ctr_taken(input ctr_e c);
        return (c == CTR_WT) || (c == CTR_ST);
    endfunction

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [WIDTH-1:0]     target_q [BTB_DEPTH];
    ctr_e                 ctr_q    [BTB_DEPTH];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic             entry_we, target_we;
    ctr_e             ctr_d;

    assign lk_idx = lookup_pc_i[OFF +: IDX];
    assign lk_tag = lookup_pc_i[WIDTH-1 -: TAG_W];
    assign up_idx = upd_pc_i[OFF +: IDX];
    assign up_tag = upd_pc_i[WIDTH-1 -: TAG_W];

    // Byte-offset bits below the instruction alignment never select an entry.
    if (OFF > 0) begin : g_offset
        logic unused_offset;
        assign unused_offset = ^{lookup_pc_i[OFF-1:0], upd_pc_i[OFF-1:0]};
    end

    always_comb begin
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o  = lk_hit && ctr_taken(ctr_q[lk_idx]);
        pred_target_o = pred_taken_o ? target_q[lk_idx] : '0;
    end

    // A not-taken miss leaves the victim entry untouched.
    always_comb begin
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        entry_we  = upd_en_i && (up_hit || upd_taken_i);
        target_we = upd_en_i && upd_taken_i;
        if (!up_hit)          ctr_d = CTR_INIT;
        else if (upd_taken_i) ctr_d = sat_inc(ctr_q[up_idx]);
        else                  ctr_d = sat_dec(ctr_q[up_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (target_we) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (entry_we) begin
            tag_q[up_idx] <= up_tag;
            ctr_q[up_idx] <= ctr_d;
        end
        if (target_we) begin
            target_q[up_idx] <= upd_target_i;
        end
    end

endmodule

// File: rtl/pc_unit_btb.sv
// Fetch PC register with next-PC priority: reset, EX redirect, cache/hazard
// hold, BTB-predicted target, then sequential increment.
module pc_unit_btb
    import pc_unit_btb_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               BTB_DEPTH    = 16,
    parameter int               INSTR_BYTES  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic            clk,
    input logic            rst,
    pc_unit_btb_if.slave   bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;

    pc_unit_btb_btb #(
        .WIDTH       (WIDTH),
        .BTB_DEPTH   (BTB_DEPTH),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc_i   (pc_q),
        .upd_en_i      (bus.upd_en),
        .upd_pc_i      (bus.upd_pc),
        .upd_target_i  (bus.upd_target),
        .upd_taken_i   (bus.upd_taken),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target)
    );

    // Redirect overrides a hold so a mispredict is never lost behind a miss.
    always_comb begin
        pc_d = pc_q + WIDTH'(INSTR_BYTES);
        if (bus.redirect)                pc_d = bus.redirect_pc;
        else if (!bus.hit || bus.stall)  pc_d = pc_q;
        else if (pred_taken)             pc_d = pred_target;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_VECTOR;
        else     pc_q <= pc_d;
    end

    assign bus.outPC       = pc_q;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;

endmodule
